// File: rtl/sdram_pkg.sv
// sdram_pkg: constants shared with the SDRAM controller and the stream reader state encoding
package sdram_pkg;
    localparam int SDRAM_ADDR_WIDTH = 25;
    localparam int SDRAM_DATA_WIDTH = 16;
    typedef enum logic [1:0] {Idle, Issue, Drain, Done} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO holding returned SDRAM read words
//   clk, rst          clock and asynchronous active-high reset
//   push_i, data_i    write port
//   pop_i, data_o     read port; data_o is the head word whenever empty_o is low
//   full_o, empty_o   occupancy flags
//   count_o           number of stored words
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic pop_ok;
    assign pop_ok  = pop_i & ~empty_o;
    assign empty_o = count_q == '0;
    assign full_o  = count_q == CW'(FIFO_DEPTH);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];
    always_ff @(posedge clk)
        if (push_i) mem_q[wr_q] <= data_i;
    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push_i);
            rd_q    <= rd_q + AW'(pop_ok);
            count_q <= count_q + CW'(push_i) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/sdram_stream_reader.sv
// sdram_stream_reader: Avalon-MM read master streaming a block of SDRAM words out through a FIFO
//   ipClk, ipReset                          clock, asynchronous active-high reset
//   ipStart, ipBaseAddress, ipLength        transfer request (sampled in Idle)
//   opBusy, opDone                          transfer status
//   opAddress, opRead, ipWaitRequest        Avalon read command
//   ipReadData, ipReadDataValid             Avalon read response
//   opData, opValid, ipReady                output stream (FIFO head, show-ahead)
module sdram_stream_reader
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH = SDRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SDRAM_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    input  logic                  ipStart,
    input  logic [ADDR_WIDTH-1:0] ipBaseAddress,
    input  logic [ADDR_WIDTH-1:0] ipLength,
    output logic                  opBusy,
    output logic                  opDone,
    output logic [ADDR_WIDTH-1:0] opAddress,
    output logic                  opRead,
    input  logic                  ipWaitRequest,
    input  logic [DATA_WIDTH-1:0] ipReadData,
    input  logic                  ipReadDataValid,
    output logic [DATA_WIDTH-1:0] opData,
    output logic                  opValid,
    input  logic                  ipReady
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);
    state_t state_q;
    logic [ADDR_WIDTH-1:0] addr_q, remaining_q, remaining_d;
    logic [CW-1:0] pending_q, pending_d, fifo_count, fifo_count_d;
    logic read_q, busy_q, done_q;
    logic accept, push, pop, credit_ok, fifo_full, fifo_empty;
    // Responses arriving in Idle belong to a transfer cut short by reset.
    assign accept       = read_q & ~ipWaitRequest;
    assign push         = ipReadDataValid & (state_q != Idle);
    assign pop          = opValid & ipReady;
    assign pending_d    = pending_q + CW'(accept) - CW'(push);
    assign fifo_count_d = fifo_count + CW'(push) - CW'(pop);
    assign remaining_d  = remaining_q - ADDR_WIDTH'(accept);
    // Next-cycle credit: every outstanding read plus every buffered word must fit in the FIFO.
    assign credit_ok    = ({1'b0, pending_d} + {1'b0, fifo_count_d}) < DEPTH;
    assign opAddress    = addr_q;
    assign opRead       = read_q;
    assign opBusy       = busy_q;
    assign opDone       = done_q;
    assign opValid      = ~fifo_empty;
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state_q     <= Idle;
            addr_q      <= '0;
            remaining_q <= '0;
            pending_q   <= '0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            done_q    <= 1'b0;
            case (state_q)
                Idle: if (ipStart) begin
                    addr_q      <= ipBaseAddress;
                    remaining_q <= ipLength;
                    busy_q      <= 1'b1;
                    read_q      <= ipLength != '0;
                    state_q     <= ipLength == '0 ? Done : Issue;
                end
                Issue: begin
                    addr_q      <= addr_q + ADDR_WIDTH'(accept);
                    remaining_q <= remaining_d;
                    // A stalled request is held until the controller takes it.
                    read_q      <= (read_q & ipWaitRequest) | (remaining_d != '0 && credit_ok);
                    state_q     <= remaining_d == '0 ? Drain : Issue;
                end
                Drain: state_q <= (pending_q == '0 && fifo_empty) ? Done : Drain;
                Done: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= Idle;
                end
                default: state_q <= Idle;
            endcase
        end
    end
    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ipClk),
        .rst     (ipReset),
        .push_i  (push),
        .data_i  (ipReadData),
        .pop_i   (pop),
        .data_o  (opData),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
    assert property (@(posedge ipClk) disable iff (ipReset) !(push && fifo_full));
endmodule

// File: tb/tb_sdram_stream_reader.sv
// tb_sdram_stream_reader: scoreboard bench with an Avalon slave model returning data 3 cycles after each read
module tb_sdram_stream_reader;
    localparam int AW = 25;
    localparam int DW = 16;
    logic ipClk = 1'b0;
    logic ipReset = 1'b1;
    logic ipStart = 1'b0;
    logic ipWaitRequest = 1'b0;
    logic ipReadDataValid = 1'b0;
    logic ipReady = 1'b0;
    logic [AW-1:0] ipBaseAddress = '0;
    logic [AW-1:0] ipLength = '0;
    logic [DW-1:0] ipReadData = '0;
    logic [AW-1:0] opAddress;
    logic [DW-1:0] opData;
    logic opBusy, opDone, opRead, opValid;

    sdram_stream_reader dut (
        .ipClk           (ipClk),
        .ipReset         (ipReset),
        .ipStart         (ipStart),
        .ipBaseAddress   (ipBaseAddress),
        .ipLength        (ipLength),
        .opBusy          (opBusy),
        .opDone          (opDone),
        .opAddress       (opAddress),
        .opRead          (opRead),
        .ipWaitRequest   (ipWaitRequest),
        .ipReadData      (ipReadData),
        .ipReadDataValid (ipReadDataValid),
        .opData          (opData),
        .opValid         (opValid),
        .ipReady         (ipReady)
    );

    always #5 ipClk = ~ipClk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rsp_t;
    rsp_t rq[$];

    always @(posedge ipClk) cyc++;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return a[15:0] ^ {7'd0, a[24:16]} ^ 16'hC3A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ipClk);
        #1;
    endtask

    task automatic expect_word(input logic [AW-1:0] a);
        exp_addr.push_back(a);
        exp_data.push_back(mem(a));
    endtask

    task automatic start_xfer(input logic [AW-1:0] base, input logic [AW-1:0] len);
        ipBaseAddress = base;
        ipLength = len;
        ipStart = 1'b1;
        tick();
        ipStart = 1'b0;
        check("busy_after_start", 32'(opBusy), 1);
        check("first_read_latency", 32'(opRead), 32'(len != '0));
    endtask

    task automatic finish_xfer(input string name, input int bound);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < bound) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 32'(done_cnt != d0), 1);
        check({name, "_busy_low"}, 32'(opBusy), 0);
        check({name, "_fifo_empty"}, 32'(opValid), 0);
        repeat (3) tick();
        check({name, "_one_done"}, 32'(done_cnt - d0), 1);
        check({name, "_reads_left"}, 32'(exp_addr.size()), 0);
        check({name, "_words_left"}, 32'(exp_data.size()), 0);
    endtask

    // Avalon slave: answers each accepted read 3 cycles later, in order.
    initial begin
        rsp_t r;
        forever begin
            @(posedge ipClk);
            #1;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                ipReadDataValid = 1'b1;
                ipReadData = rq[0].d;
                void'(rq.pop_front());
            end else begin
                ipReadDataValid = 1'b0;
            end
            @(negedge ipClk);
            if (!ipReset && opRead && !ipWaitRequest) begin
                r.due = cyc + 3;
                r.d = mem(opAddress);
                rq.push_back(r);
            end
        end
    end

    // Monitor: compares every accepted read and every consumed stream word against the scoreboard.
    initial begin
        forever begin
            @(negedge ipClk);
            if (!ipReset) begin
                if (opRead && !ipWaitRequest) begin
                    acc_cnt++;
                    if (exp_addr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_read: got address 0x%0h, expected no read", opAddress);
                    end else begin
                        check("read_addr", 32'(opAddress), 32'(exp_addr.pop_front()));
                    end
                end
                if (opValid && ipReady) begin
                    if (exp_data.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word: got data 0x%0h, expected no word", opData);
                    end else begin
                        check("stream_data", 32'(opData), 32'(exp_data.pop_front()));
                    end
                end
                if (opDone) done_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        int d0;
        int n;
        repeat (2) tick();
        check("rst_busy", 32'(opBusy), 0);
        check("rst_done", 32'(opDone), 0);
        check("rst_read", 32'(opRead), 0);
        check("rst_addr", 32'(opAddress), 0);
        check("rst_valid", 32'(opValid), 0);
        ipReset = 1'b0;
        ipReady = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) expect_word(25'h100 + 25'(i));
        start_xfer(25'h100, 25'd4);
        check("t1_first_addr", 32'(opAddress), 32'h100);
        finish_xfer("t1", 100);

        ipReady = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 40; i++) expect_word(25'h400 + 25'(i));
        start_xfer(25'h400, 25'd40);
        repeat (40) tick();
        check("t2_reads_capped", 32'(acc_cnt - a0), 16);
        check("t2_read_stalled", 32'(opRead), 0);
        check("t2_valid_held", 32'(opValid), 1);
        ipReady = 1'b1;
        finish_xfer("t2", 500);
        check("t2_reads_total", 32'(acc_cnt - a0), 40);

        for (int i = 0; i < 6; i++) expect_word(25'h500 + 25'(i));
        start_xfer(25'h500, 25'd6);
        tick();
        ipWaitRequest = 1'b1;
        repeat (5) begin
            tick();
            check("t3_hold_read", 32'(opRead), 1);
            check("t3_hold_addr", 32'(opAddress), 32'h501);
        end
        ipWaitRequest = 1'b0;
        finish_xfer("t3", 100);

        expect_word(25'h1FFFFFE);
        expect_word(25'h1FFFFFF);
        expect_word(25'h0000000);
        expect_word(25'h0000001);
        start_xfer(25'h1FFFFFE, 25'd4);
        finish_xfer("t4", 100);

        a0 = acc_cnt;
        d0 = done_cnt;
        start_xfer(25'h600, 25'd0);
        check("t5_done_early", 32'(opDone), 0);
        tick();
        check("t5_done_pulse", 32'(opDone), 1);
        check("t5_busy_at_done", 32'(opBusy), 0);
        tick();
        check("t5_done_cleared", 32'(opDone), 0);
        check("t5_no_reads", 32'(acc_cnt - a0), 0);
        check("t5_done_count", 32'(done_cnt - d0), 1);

        for (int i = 0; i < 4; i++) expect_word(25'h200 + 25'(i));
        start_xfer(25'h200, 25'd4);
        ipBaseAddress = 25'h1234;
        ipLength = 25'd7;
        ipStart = 1'b1;
        tick();
        ipStart = 1'b0;
        finish_xfer("t5_busy_start", 100);

        a0 = acc_cnt;
        for (int i = 0; i < 8; i++) expect_word(25'h300 + 25'(i));
        start_xfer(25'h300, 25'd8);
        n = 0;
        while (acc_cnt - a0 < 3 && n < 50) begin
            tick();
            n++;
        end
        check("t6_three_issued", 32'(acc_cnt - a0), 3);
        ipReset = 1'b1;
        #1;
        check("t6_rst_read", 32'(opRead), 0);
        check("t6_rst_busy", 32'(opBusy), 0);
        check("t6_rst_done", 32'(opDone), 0);
        check("t6_rst_addr", 32'(opAddress), 0);
        check("t6_rst_valid", 32'(opValid), 0);
        exp_addr.delete();
        exp_data.delete();
        tick();
        ipReset = 1'b0;
        repeat (8) begin
            tick();
            check("t6_stale_valid", 32'(opValid), 0);
        end
        check("t6_idle_busy", 32'(opBusy), 0);
        check("t6_idle_read", 32'(opRead), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
